// File: rtl/snake_turn_queue.sv
// Snake player-input front end: four debounced buttons become turn requests,
// filtered by a relative or absolute turn rule and buffered for one-per-tick apply.

module snake_turn_debounce #(
  parameter int CYCLES = 250000,
  parameter int BITS   = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  logic            s1, s2, level;
  logic [BITS-1:0] cnt;

  // press is raised at the same edge the debounced level rises
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == BITS'(CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + BITS'(1);
      end
    end
  end
endmodule

module snake_turn_queue #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         DB_BITS         = 18,
  parameter int         QUEUE_DEPTH     = 4,
  parameter int         PTR_BITS        = 2,
  parameter int         MODE            = 0,
  parameter logic [1:0] INIT_DIR        = 2'b00
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              game_enable,
  input  logic              game_tik,
  input  logic              btn_right,
  input  logic              btn_left,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [1:0]        direction,
  output logic              right,
  output logic              left,
  output logic              up,
  output logic              down,
  output logic [PTR_BITS:0] queue_count,
  output logic              queue_full,
  output logic              turn_dropped
);
  localparam logic [PTR_BITS:0] DEPTH = (PTR_BITS + 1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic       vld;
    logic [1:0] dir;
  } turn_t;

  // bit index equals the direction code: 0 right, 1 up, 2 left, 3 down
  logic [3:0] raw, press;
  assign raw = {btn_down, btn_left, btn_up, btn_right};

  snake_turn_debounce #(.CYCLES(DEBOUNCE_CYCLES), .BITS(DB_BITS)) u_db [3:0] (
    .clk   (clock_25),
    .reset (reset),
    .raw   (raw),
    .press (press)
  );

  logic [QUEUE_DEPTH-1:0][1:0] mem;
  logic [PTR_BITS-1:0]         wptr, rptr;
  logic [PTR_BITS:0]           count;
  logic [1:0]                  ref_dir;
  turn_t                       cand;
  logic                        full, enq_try, enq, pop;

  // new turns are judged against the last queued turn, not the live heading
  assign ref_dir = (count != '0) ? mem[wptr - PTR_BITS'(1)] : direction;

  always_comb begin
    cand = '0;
    if (MODE == 0) begin
      if (press[0] && !press[2])      cand = '{vld: 1'b1, dir: ref_dir - 2'd1};
      else if (press[2] && !press[0]) cand = '{vld: 1'b1, dir: ref_dir + 2'd1};
    end else begin
      cand.vld = |press;
      if (press[0])      cand.dir = 2'd0;
      else if (press[1]) cand.dir = 2'd1;
      else if (press[2]) cand.dir = 2'd2;
      else               cand.dir = 2'd3;
      if (cand.dir == ref_dir || cand.dir == (ref_dir ^ 2'b10)) cand.vld = 1'b0;
    end
  end

  // a pop in the same cycle does not free a slot for the incoming turn
  assign full    = (count == DEPTH);
  assign enq_try = cand.vld & game_enable;
  assign enq     = enq_try & ~full;
  assign pop     = game_tik & game_enable & (count != '0);

  always_ff @(posedge clock_25) begin
    if (reset) begin
      direction    <= INIT_DIR;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      turn_dropped <= 1'b0;
    end else begin
      turn_dropped <= enq_try & full;
      if (!game_enable) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (enq) wptr <= wptr + PTR_BITS'(1);
        if (pop) begin
          rptr      <= rptr + PTR_BITS'(1);
          direction <= mem[rptr];
        end
        count <= count + (PTR_BITS + 1)'(enq) - (PTR_BITS + 1)'(pop);
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (enq) mem[wptr] <= cand.dir;
  end

  assign queue_count = count;
  assign queue_full  = full;
  assign right       = (direction == 2'b00);
  assign up          = (direction == 2'b01);
  assign left        = (direction == 2'b10);
  assign down        = (direction == 2'b11);
endmodule

// File: tb/tb_snake_turn_queue.sv
// Directed vector table for snake_turn_queue; one relative and one absolute instance share stimulus.

module tb_snake_turn_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, game_enable = 1'b0, game_tik = 1'b0;
  logic       btn_right = 1'b0, btn_left = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [1:0] dir0, dir1;
  logic       r0, l0, u0, d0, r1, l1, u1, d1;
  logic [2:0] cnt0, cnt1;
  logic       full0, full1, drop0, drop1;

  snake_turn_queue #(.DEBOUNCE_CYCLES(4), .DB_BITS(3), .QUEUE_DEPTH(4), .PTR_BITS(2),
                     .MODE(0), .INIT_DIR(2'b00)) dut0 (
    .clock_25(clk), .reset(reset), .game_enable(game_enable), .game_tik(game_tik),
    .btn_right(btn_right), .btn_left(btn_left), .btn_up(btn_up), .btn_down(btn_down),
    .direction(dir0), .right(r0), .left(l0), .up(u0), .down(d0),
    .queue_count(cnt0), .queue_full(full0), .turn_dropped(drop0));

  snake_turn_queue #(.DEBOUNCE_CYCLES(4), .DB_BITS(3), .QUEUE_DEPTH(4), .PTR_BITS(2),
                     .MODE(1), .INIT_DIR(2'b00)) dut1 (
    .clock_25(clk), .reset(reset), .game_enable(game_enable), .game_tik(game_tik),
    .btn_right(btn_right), .btn_left(btn_left), .btn_up(btn_up), .btn_down(btn_down),
    .direction(dir1), .right(r1), .left(l1), .up(u1), .down(d1),
    .queue_count(cnt1), .queue_full(full1), .turn_dropped(drop1));

  typedef struct {
    logic       rst;
    logic       en;
    logic       tik;
    logic [3:0] btn;   // {down, left, up, right}
    logic       chk;
    logic       m;
    logic [1:0] dir;
    logic [2:0] cnt;
    logic       drop;
    int         id;
  } vec_t;

  vec_t tbl[$];
  logic en_s = 1'b1;
  logic m_s  = 1'b0;
  int   checks = 0, failures = 0;

  localparam logic [3:0] R = 4'b0001, U = 4'b0010, L = 4'b0100, D = 4'b1000, N = 4'b0000;

  task automatic add(input logic rst, input logic tik, input logic [3:0] btn, input logic chk,
                     input logic [1:0] dir, input logic [2:0] cnt, input logic drop, input int id);
    vec_t v;
    v.rst = rst; v.en = en_s; v.tik = tik; v.btn = btn; v.chk = chk; v.m = m_s;
    v.dir = dir; v.cnt = cnt; v.drop = drop; v.id = id;
    tbl.push_back(v);
  endtask

  // 6 cycles held then 6 released; the press lands at the 7th cycle
  task automatic press(input logic [3:0] btn, input logic tik6, input logic [1:0] dir,
                       input logic [2:0] cnt, input logic drop, input int id);
    for (int k = 0; k < 6; k++) add(1'b0, 1'b0, btn, 1'b0, 2'b00, 3'd0, 1'b0, id);
    add(1'b0, tik6, N, 1'b1, dir, cnt, drop, id);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, N, 1'b0, 2'b00, 3'd0, 1'b0, id);
    add(1'b0, 1'b0, N, 1'b1, dir, cnt, 1'b0, id);
  endtask

  task automatic tick(input logic [1:0] dir, input logic [2:0] cnt, input int id);
    add(1'b0, 1'b1, N, 1'b1, dir, cnt, 1'b0, id);
  endtask

  task automatic rst1(input int id);
    add(1'b1, 1'b0, N, 1'b1, 2'b00, 3'd0, 1'b0, id);
  endtask

  task automatic check(input int idx, input int id, input string what,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec=%0d id=%0d %s got=%0h exp=%0h", idx, id, what, act, exp);
    end
  endtask

  initial begin
    logic [1:0] a_dir;
    logic [2:0] a_cnt;
    logic       a_drop, a_full;
    logic [3:0] a_hot, e_hot, one;

    // reset
    m_s = 1'b0;
    add(1'b1, 1'b0, N, 1'b0, 2'b00, 3'd0, 1'b0, 1);
    add(1'b1, 1'b0, N, 1'b0, 2'b00, 3'd0, 1'b0, 1);
    rst1(1);
    m_s = 1'b1; rst1(2); m_s = 1'b0;

    // 2-cycle glitch on right must not produce a press
    add(1'b0, 1'b0, R, 1'b0, 2'b00, 3'd0, 1'b0, 3);
    add(1'b0, 1'b0, R, 1'b0, 2'b00, 3'd0, 1'b0, 3);
    for (int k = 0; k < 6; k++) add(1'b0, 1'b0, N, 1'b1, 2'b00, 3'd0, 1'b0, 3);

    // 10-cycle press: count still 0 after 6 edges, 1 after 7
    for (int k = 0; k < 10; k++)
      add(1'b0, 1'b0, R, (k == 5 || k == 6), 2'b00, (k == 6) ? 3'd1 : 3'd0, 1'b0, 4);
    for (int k = 0; k < 6; k++) add(1'b0, 1'b0, N, (k == 5), 2'b00, 3'd1, 1'b0, 4);
    tick(2'b11, 3'd0, 5);
    press(R | L, 1'b0, 2'b11, 3'd0, 1'b0, 6);

    // four lefts fill the queue, fifth is dropped, then drain
    rst1(7);
    press(L, 1'b0, 2'b00, 3'd1, 1'b0, 8);
    press(L, 1'b0, 2'b00, 3'd2, 1'b0, 8);
    press(L, 1'b0, 2'b00, 3'd3, 1'b0, 8);
    press(L, 1'b0, 2'b00, 3'd4, 1'b0, 8);
    press(L, 1'b0, 2'b00, 3'd4, 1'b1, 9);
    tick(2'b01, 3'd3, 10);
    tick(2'b10, 3'd2, 10);
    tick(2'b11, 3'd1, 10);
    tick(2'b00, 3'd0, 10);
    tick(2'b00, 3'd0, 10);

    // reset with three entries queued and a non-initial heading
    rst1(11);
    press(L, 1'b0, 2'b00, 3'd1, 1'b0, 11);
    press(L, 1'b0, 2'b00, 3'd2, 1'b0, 11);
    press(L, 1'b0, 2'b00, 3'd3, 1'b0, 11);
    tick(2'b01, 3'd2, 11);
    press(L, 1'b0, 2'b01, 3'd3, 1'b0, 11);
    rst1(11);

    // absolute mode: reversal and repeat filter, priority
    m_s = 1'b1;
    rst1(12);
    press(L,     1'b0, 2'b00, 3'd0, 1'b0, 12);
    press(U,     1'b0, 2'b00, 3'd1, 1'b0, 12);
    press(D,     1'b0, 2'b00, 3'd1, 1'b0, 12);
    press(R | U, 1'b0, 2'b00, 3'd2, 1'b0, 12);
    press(R | U, 1'b0, 2'b00, 3'd2, 1'b0, 12);
    tick(2'b01, 3'd1, 12);
    tick(2'b00, 3'd0, 12);
    m_s = 1'b0;

    // press landing on a tik with empty queue; full queue plus press plus tik
    rst1(13);
    press(R, 1'b1, 2'b00, 3'd1, 1'b0, 13);
    tick(2'b11, 3'd0, 13);
    press(L, 1'b0, 2'b11, 3'd1, 1'b0, 13);
    press(L, 1'b0, 2'b11, 3'd2, 1'b0, 13);
    press(L, 1'b0, 2'b11, 3'd3, 1'b0, 13);
    press(L, 1'b0, 2'b11, 3'd4, 1'b0, 13);
    press(L, 1'b1, 2'b00, 3'd3, 1'b1, 13);

    // game_enable low flushes, holds heading, ignores presses
    rst1(14);
    press(L, 1'b0, 2'b00, 3'd1, 1'b0, 14);
    press(L, 1'b0, 2'b00, 3'd2, 1'b0, 14);
    press(L, 1'b0, 2'b00, 3'd3, 1'b0, 14);
    tick(2'b01, 3'd2, 14);
    en_s = 1'b0;
    add(1'b0, 1'b0, N, 1'b1, 2'b01, 3'd0, 1'b0, 14);
    press(L, 1'b0, 2'b01, 3'd0, 1'b0, 14);
    tick(2'b01, 3'd0, 14);
    en_s = 1'b1;
    press(L, 1'b0, 2'b01, 3'd1, 1'b0, 14);
    tick(2'b10, 3'd0, 14);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset       = tbl[i].rst;
      game_enable = tbl[i].en;
      game_tik    = tbl[i].tik;
      {btn_down, btn_left, btn_up, btn_right} = tbl[i].btn;
      @(posedge clk);
      #1;
      if (tbl[i].chk) begin
        a_dir  = tbl[i].m ? dir1  : dir0;
        a_cnt  = tbl[i].m ? cnt1  : cnt0;
        a_drop = tbl[i].m ? drop1 : drop0;
        a_full = tbl[i].m ? full1 : full0;
        a_hot  = tbl[i].m ? {d1, l1, u1, r1} : {d0, l0, u0, r0};
        one    = 4'b0001;
        e_hot  = one << tbl[i].dir;
        check(i, tbl[i].id, "direction",    8'(a_dir),  8'(tbl[i].dir));
        check(i, tbl[i].id, "queue_count",  8'(a_cnt),  8'(tbl[i].cnt));
        check(i, tbl[i].id, "turn_dropped", 8'(a_drop), 8'(tbl[i].drop));
        check(i, tbl[i].id, "queue_full",   8'(a_full), 8'(tbl[i].cnt == 3'd4));
        check(i, tbl[i].id, "onehot",       8'(a_hot),  8'(e_hot));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
